// File: rtl/avr_spi_slave_if.sv
// AVR SPI slave link bundle: SPI pins, link-ready, tx fetch port and rx stream.
// AVR_SPI_OVERRUN_EN adds the sticky rx_overrun flag.
interface avr_spi_slave_if;
  logic       ready;
  logic       spi_ss;
  logic       spi_sck;
  logic       spi_mosi;
  logic       spi_miso;
  logic       miso_oe;
  logic [7:0] tx_data;
  logic       tx_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
`ifdef AVR_SPI_OVERRUN_EN
  logic       rx_overrun;
`endif

  modport slave (
    input  ready, spi_ss, spi_sck, spi_mosi, tx_data, rx_ready,
    output spi_miso, miso_oe, tx_ack, rx_data, rx_valid
`ifdef AVR_SPI_OVERRUN_EN
    , output rx_overrun
`endif
  );

  modport master (
    output ready, spi_ss, spi_sck, spi_mosi, tx_data, rx_ready,
    input  spi_miso, miso_oe, tx_ack, rx_data, rx_valid
`ifdef AVR_SPI_OVERRUN_EN
    , input rx_overrun
`endif
  );
endinterface

// File: rtl/avr_spi_slave.sv
// SPI mode-0 slave (MSB first) for the AVR-to-FPGA link, gated by the cclk ready signal.
// Define AVR_SPI_OVERRUN_EN to add the sticky rx_overrun output.
module avr_spi_slave #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  avr_spi_slave_if.slave  bus
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t                 state, state_next;
  logic [SYNC_STAGES-1:0] ss_sr, sck_sr, mosi_sr;
  logic                   sck_prev;
  logic                   ss_sync, sck_sync, mosi_sync;
  logic                   act, sck_rise, sck_fall;

  logic [2:0]             bit_cnt;
  logic [7:0]             tx_shift, rx_shift, rx_next;
  logic [7:0]             rx_data;
  logic                   rx_valid;
  logic                   first_byte;

  logic                   enter, leave, load_tx, shift_tx, rise_en, first_clr;
  logic                   byte_done, accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      ss_sr    <= '1;
      sck_sr   <= '0;
      mosi_sr  <= '0;
      sck_prev <= 1'b0;
    end else begin
      ss_sr    <= {ss_sr[SYNC_STAGES-2:0], bus.spi_ss};
      sck_sr   <= {sck_sr[SYNC_STAGES-2:0], bus.spi_sck};
      mosi_sr  <= {mosi_sr[SYNC_STAGES-2:0], bus.spi_mosi};
      sck_prev <= sck_sr[SYNC_STAGES-1];
    end
  end

  assign ss_sync   = ss_sr[SYNC_STAGES-1];
  assign sck_sync  = sck_sr[SYNC_STAGES-1];
  assign mosi_sync = mosi_sr[SYNC_STAGES-1];
  assign act       = bus.ready & ~ss_sync;
  assign sck_rise  = sck_sync & ~sck_prev;
  assign sck_fall  = ~sck_sync & sck_prev;
  assign rx_next   = {rx_shift[6:0], mosi_sync};
  assign byte_done = rise_en && (bit_cnt == 3'd7);
  assign accept    = rx_valid && bus.rx_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    enter      = 1'b0;
    leave      = 1'b0;
    load_tx    = 1'b0;
    shift_tx   = 1'b0;
    rise_en    = 1'b0;
    first_clr  = 1'b0;
    case (state)
      IDLE: begin
        if (act) begin
          state_next = XFER;
          enter      = 1'b1;
          load_tx    = 1'b1;
        end
      end
      XFER: begin
        if (!act) begin
          state_next = IDLE;
          leave      = 1'b1;
        end else begin
          if (sck_rise) begin
            rise_en   = 1'b1;
            first_clr = 1'b1;
          end
          // A byte boundary on the very first fall was already served at select time.
          if (sck_fall) begin
            if (bit_cnt != 3'd0) shift_tx = 1'b1;
            else if (first_byte) first_clr = 1'b1;
            else load_tx = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt    <= '0;
      tx_shift   <= '0;
      rx_shift   <= '0;
      first_byte <= 1'b0;
    end else begin
      if (enter || leave) bit_cnt <= '0;
      else if (rise_en)   bit_cnt <= bit_cnt + 3'd1;

      if (rise_en) rx_shift <= rx_next;

      if (enter)          first_byte <= 1'b1;
      else if (first_clr) first_byte <= 1'b0;

      if (load_tx)       tx_shift <= bus.tx_data;
      else if (shift_tx) tx_shift <= {tx_shift[6:0], 1'b0};
    end
  end

  // A new byte outranks the consumer handshake, so overrun keeps the newest byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else if (!bus.ready) begin
      rx_valid <= 1'b0;
    end else if (byte_done) begin
      rx_data  <= rx_next;
      rx_valid <= 1'b1;
    end else if (accept) begin
      rx_valid <= 1'b0;
    end
  end

`ifdef AVR_SPI_OVERRUN_EN
  logic rx_overrun;

  always_ff @(posedge clk) begin
    if (rst || !bus.ready)                         rx_overrun <= 1'b0;
    else if (byte_done && rx_valid && !bus.rx_ready) rx_overrun <= 1'b1;
    else if (accept)                               rx_overrun <= 1'b0;
  end

  assign bus.rx_overrun = rx_overrun;
`endif

  assign bus.spi_miso = tx_shift[7];
  assign bus.miso_oe  = (state == XFER);
  assign bus.tx_ack   = load_tx & ~rst;
  assign bus.rx_data  = rx_data;
  assign bus.rx_valid = rx_valid;

endmodule

// File: tb/tb_avr_spi_slave.sv
// Self-checking bench for avr_spi_slave: vector table of single-byte frames plus
// multi-byte, overrun, abort, ready-drop and reset sequences.
module tb_avr_spi_slave;

  localparam int unsigned PH = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  avr_spi_slave_if bus ();

  avr_spi_slave #(.SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [7:0] mosi;
    logic [7:0] tx;
    logic [7:0] exp_rx;
    logic [7:0] exp_miso;
  } vec_t;

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned ack_cnt = 0;
  int unsigned valid_cycles = 0;
  logic [7:0]  tx_q[$];
  logic [7:0]  rx_q[$];
  bit          pend = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic wclk(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame_start();
    bus.spi_ss = 1'b0;
    wclk(PH);
  endtask

  // Mode-0 bits, MSB first; miso is captured just before each rising sck.
  // When last is set, ss is raised while sck is still high after the final bit.
  task automatic spi_bits(input logic [7:0] b, input int unsigned nbits, input bit last,
                          output logic [7:0] mb);
    mb = '0;
    for (int unsigned i = 0; i < nbits; i++) begin
      bus.spi_mosi = b[7-i];
      wclk(PH);
      mb = {mb[6:0], bus.spi_miso};
      bus.spi_sck = 1'b1;
      wclk(PH);
      if (last && (i == nbits - 1)) begin
        bus.spi_ss = 1'b1;
        wclk(PH);
      end
      bus.spi_sck = 1'b0;
    end
  endtask

  // tx source: presents the queue head, advances one entry per tx_ack.
  initial begin
    bus.tx_data = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (pend) begin
        if (tx_q.size() > 0) void'(tx_q.pop_front());
        pend = 1'b0;
      end
      bus.tx_data = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
      @(negedge clk);
      if (bus.tx_ack === 1'b1) begin
        ack_cnt++;
        pend = 1'b1;
      end
    end
  end

  // rx scoreboard: every accepted byte must match the head of rx_q.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.rx_valid === 1'b1) valid_cycles++;
      if (bus.rx_valid === 1'b1 && bus.rx_ready === 1'b1) begin
        if (rx_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rx_unexpected: got 0x%0h expected no byte", bus.rx_data);
        end else begin
          chk("rx_data", {24'h0, bus.rx_data}, {24'h0, rx_q.pop_front()});
        end
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [4];
    logic [7:0]  mb, m0, m1, m2;
    int unsigned a0, v0;

    vecs[0] = '{8'hA5, 8'h3C, 8'hA5, 8'h3C};
    vecs[1] = '{8'h00, 8'hFF, 8'h00, 8'hFF};
    vecs[2] = '{8'hFF, 8'h00, 8'hFF, 8'h00};
    vecs[3] = '{8'h96, 8'h69, 8'h96, 8'h69};

    bus.ready    = 1'b1;
    bus.spi_ss   = 1'b1;
    bus.spi_sck  = 1'b0;
    bus.spi_mosi = 1'b0;
    bus.rx_ready = 1'b1;

    wclk(3);
    chk("rst_miso",     {31'h0, bus.spi_miso}, 32'h0);
    chk("rst_miso_oe",  {31'h0, bus.miso_oe},  32'h0);
    chk("rst_tx_ack",   {31'h0, bus.tx_ack},   32'h0);
    chk("rst_rx_data",  {24'h0, bus.rx_data},  32'h0);
    chk("rst_rx_valid", {31'h0, bus.rx_valid}, 32'h0);
`ifdef AVR_SPI_OVERRUN_EN
    chk("rst_overrun",  {31'h0, bus.rx_overrun}, 32'h0);
`endif
    rst = 1'b0;
    wclk(PH);

    // Single-byte frames.
    for (int unsigned k = 0; k < 4; k++) begin
      tx_q.delete();
      tx_q.push_back(vecs[k].tx);
      rx_q.push_back(vecs[k].exp_rx);
      wclk(2);
      a0 = ack_cnt;
      v0 = valid_cycles;
      frame_start();
      chk("frame_miso_oe", {31'h0, bus.miso_oe}, 32'h1);
      spi_bits(vecs[k].mosi, 8, 1'b1, mb);
      wclk(PH);
      chk("frame_miso",    {24'h0, mb}, {24'h0, vecs[k].exp_miso});
      chk("frame_acks",    ack_cnt - a0, 32'd1);
      chk("frame_valid1",  valid_cycles - v0, 32'd1);
      chk("frame_oe_off",  {31'h0, bus.miso_oe}, 32'h0);
    end

    // Three back-to-back bytes in one frame.
    tx_q.delete();
    tx_q.push_back(8'h10); tx_q.push_back(8'h20); tx_q.push_back(8'h30);
    rx_q.push_back(8'h01); rx_q.push_back(8'h02); rx_q.push_back(8'h03);
    wclk(2);
    a0 = ack_cnt;
    frame_start();
    spi_bits(8'h01, 8, 1'b0, m0);
    spi_bits(8'h02, 8, 1'b0, m1);
    spi_bits(8'h03, 8, 1'b1, m2);
    wclk(PH);
    chk("b2b_miso0", {24'h0, m0}, 32'h10);
    chk("b2b_miso1", {24'h0, m1}, 32'h20);
    chk("b2b_miso2", {24'h0, m2}, 32'h30);
    chk("b2b_acks",  ack_cnt - a0, 32'd3);

    // Overrun: consumer stalled across two bytes.
    tx_q.delete();
    bus.rx_ready = 1'b0;
    frame_start();
    spi_bits(8'h11, 8, 1'b1, mb);
    wclk(PH);
    chk("ovr_valid1", {31'h0, bus.rx_valid}, 32'h1);
    chk("ovr_data1",  {24'h0, bus.rx_data},  32'h11);
`ifdef AVR_SPI_OVERRUN_EN
    chk("ovr_flag0",  {31'h0, bus.rx_overrun}, 32'h0);
`endif
    frame_start();
    spi_bits(8'h22, 8, 1'b1, mb);
    wclk(PH);
    chk("ovr_valid2", {31'h0, bus.rx_valid}, 32'h1);
    chk("ovr_data2",  {24'h0, bus.rx_data},  32'h22);
`ifdef AVR_SPI_OVERRUN_EN
    chk("ovr_flag1",  {31'h0, bus.rx_overrun}, 32'h1);
`endif
    rx_q.push_back(8'h22);
    bus.rx_ready = 1'b1;
    wclk(1);
    chk("ovr_drained", {31'h0, bus.rx_valid}, 32'h0);
`ifdef AVR_SPI_OVERRUN_EN
    chk("ovr_flag_clr", {31'h0, bus.rx_overrun}, 32'h0);
`endif
    wclk(PH);

    // Aborted partial byte, then a clean frame.
    tx_q.delete();
    tx_q.push_back(8'hAA);
    wclk(2);
    v0 = valid_cycles;
    frame_start();
    spi_bits(8'hFF, 5, 1'b1, mb);
    wclk(PH);
    chk("abort_oe",    {31'h0, bus.miso_oe}, 32'h0);
    chk("abort_valid", valid_cycles - v0, 32'd0);
    tx_q.delete();
    tx_q.push_back(8'hA5);
    rx_q.push_back(8'h5A);
    wclk(2);
    frame_start();
    spi_bits(8'h5A, 8, 1'b1, mb);
    wclk(PH);
    chk("abort_next_miso", {24'h0, mb}, 32'hA5);

    // Link not ready: pins toggle but nothing happens.
    tx_q.delete();
    bus.ready = 1'b0;
    a0 = ack_cnt;
    v0 = valid_cycles;
    frame_start();
    chk("nrdy_oe", {31'h0, bus.miso_oe}, 32'h0);
    spi_bits(8'hC3, 8, 1'b1, mb);
    wclk(PH);
    chk("nrdy_acks",  ack_cnt - a0, 32'd0);
    chk("nrdy_valid", valid_cycles - v0, 32'd0);
    chk("nrdy_oe2",   {31'h0, bus.miso_oe}, 32'h0);
    bus.ready = 1'b1;
    wclk(PH);

    // ready drops mid-byte while a byte is pending.
    bus.rx_ready = 1'b0;
    frame_start();
    spi_bits(8'h77, 8, 1'b1, mb);
    wclk(PH);
    chk("drop_pending", {31'h0, bus.rx_valid}, 32'h1);
    frame_start();
    spi_bits(8'h0F, 3, 1'b0, mb);
    bus.ready = 1'b0;
    wclk(1);
    chk("drop_valid", {31'h0, bus.rx_valid}, 32'h0);
    chk("drop_oe",    {31'h0, bus.miso_oe},  32'h0);
    bus.spi_ss = 1'b1;
    wclk(PH);
    bus.ready    = 1'b1;
    bus.rx_ready = 1'b1;
    wclk(PH);

    // Reset mid-byte.
    tx_q.delete();
    tx_q.push_back(8'h99);
    wclk(2);
    frame_start();
    spi_bits(8'hF0, 4, 1'b0, mb);
    rst = 1'b1;
    bus.spi_ss = 1'b1;
    wclk(1);
    chk("mrst_miso",  {31'h0, bus.spi_miso}, 32'h0);
    chk("mrst_oe",    {31'h0, bus.miso_oe},  32'h0);
    chk("mrst_ack",   {31'h0, bus.tx_ack},   32'h0);
    chk("mrst_data",  {24'h0, bus.rx_data},  32'h0);
    chk("mrst_valid", {31'h0, bus.rx_valid}, 32'h0);
    rst = 1'b0;
    wclk(PH);
    tx_q.delete();
    tx_q.push_back(8'h3C);
    rx_q.push_back(8'hC3);
    wclk(2);
    frame_start();
    spi_bits(8'hC3, 8, 1'b1, mb);
    wclk(PH);
    chk("mrst_next_miso", {24'h0, mb}, 32'h3C);

    wclk(PH);
    chk("rx_pending", rx_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
